// File: rtl/weight_loader.sv
// rtl/weight_loader.sv - stream-to-buffer weight loader for the convolution weight buffer
//
// Accepts one kernel of SIZE weight words over a valid/ready stream and turns
// it into registered buffer writes at addresses 0..SIZE-1. Signals completion
// with a one-cycle done pulse and keeps weights_valid high until the next load
// is started (or aborted, or reset).
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   start         request a kernel load (honoured only in IDLE)
//   abort         cancel the load in progress (honoured only in LOAD)
//   s_valid       weight word on s_data is valid
//   s_data        weight word
//   s_ready       loader accepts a word this cycle
//   write_en      buffer write strobe (one cycle after each accepted word)
//   write_addr    buffer write address
//   data_out      buffer write data
//   busy          high in LOAD and DONE
//   done          one-cycle pulse coinciding with the final buffer write
//   weights_valid buffer holds a complete kernel

module weight_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int SIZE       = 9,
  localparam int ADDR_W    = $clog2(SIZE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  write_en,
  output logic [ADDR_W-1:0]     write_addr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  busy,
  output logic                  done,
  output logic                  weights_valid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_BEAT = ADDR_W'(SIZE - 1);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] beat_cnt;
  logic              accept;
  logic              load_start;
  logic              load_abort;
  logic              last_beat;

  assign last_beat = (beat_cnt == LAST_BEAT);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and stream handshake. abort masks s_ready so a beat offered in
  // the abort cycle is never consumed; s_ready never looks at s_valid.
  always_comb begin
    state_next = state;
    s_ready    = 1'b0;
    accept     = 1'b0;
    load_start = 1'b0;
    load_abort = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load_start = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: begin
        s_ready = !abort;
        accept  = s_valid && !abort;
        if (abort) begin
          load_abort = 1'b1;
          state_next = IDLE;
        end else if (accept && last_beat) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Beat counter: cleared when a load starts or is aborted, parks at SIZE-1
  // after the final beat so it never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
    end else if (load_start || load_abort) begin
      beat_cnt <= '0;
    end else if (accept && !last_beat) begin
      beat_cnt <= beat_cnt + ADDR_W'(1);
    end
  end

  // Registered buffer write port; address and data hold between strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_en   <= 1'b0;
      write_addr <= '0;
      data_out   <= '0;
    end else begin
      write_en <= accept;
      if (accept) begin
        write_addr <= beat_cnt;
        data_out   <= s_data;
      end
    end
  end

  // weights_valid rises on the edge leaving DONE, i.e. once the final write
  // has landed in the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      weights_valid <= 1'b0;
    end else if (state == DONE) begin
      weights_valid <= 1'b1;
    end else if (load_start || load_abort) begin
      weights_valid <= 1'b0;
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: doc/weight_loader.md
# weight_loader

Upstream feeder for the convolution weight buffer. It accepts a stream of kernel weights over a valid/ready interface and converts it into the buffer's write port: one write per weight, with sequential addresses 0..SIZE-1. On completion it pulses `done` and holds `weights_valid` until the next load starts. The compute array gates on `weights_valid` before using the buffered kernel.

## Interface
Parameters:
- DATA_WIDTH, 8, width of one weight word
- SIZE, 9, weights per kernel; must be ≥ 2; ADDR_W = $clog2(SIZE)

Ports:
- clk  in  1  clock; all logic is rising-edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request to load one kernel; honoured only in IDLE
- abort  in  1  cancel an in-progress load; honoured only in LOAD
- s_valid  in  1  weight word on s_data is valid
- s_data  in  DATA_WIDTH  weight word
- s_ready  out  1  loader accepts a word this cycle
- write_en  out  1  buffer write strobe
- write_addr  out  ADDR_W  buffer write address
- data_out  out  DATA_WIDTH  buffer write data
- busy  out  1  high in LOAD and DONE
- done  out  1  one-cycle pulse: final weight is being written
- weights_valid  out  1  buffer holds a complete kernel

## Operation
- FSM states: IDLE, LOAD, DONE.
- IDLE:
  - start=1 → LOAD next cycle.
  - On the same edge: the beat counter clears to 0 and weights_valid clears to 0.
- LOAD:
  - s_ready = (state==LOAD) && !abort. This is combinational and does not depend on s_valid.
  - A beat is accepted when s_valid && s_ready. The beat counter then increments.
  - Accepting the beat while counter == SIZE-1 → DONE. The counter never exceeds SIZE-1 and never wraps.
  - abort=1 → IDLE next cycle. No beat is accepted that cycle. The counter resets, done does not fire, and weights_valid stays 0. Writes already issued are not undone.
- DONE:
  - Lasts exactly one cycle, then IDLE.
  - s_ready=0. start and abort are ignored.
- Write path, all registered:
  - The cycle after each accepted beat k: write_en=1, write_addr=k, data_out=that beat.
  - Otherwise write_en=0; write_addr and data_out hold their last values.
- done=1 exactly during the DONE cycle. This coincides with write_en=1 at write_addr=SIZE-1.
- weights_valid:
  - Set on the edge leaving DONE, so it is high from the first IDLE cycle after DONE.
  - Cleared by an accepted start, by abort, and by reset.
- start while busy is dropped; it is not queued.
- s_data is ignored when not accepted.
- Stalls (s_valid=0 in LOAD) are unbounded: the FSM stays in LOAD and the counter holds.
- Reset, asynchronous and any time including mid-load:
  - state=IDLE, counter=0.
  - s_ready=0, write_en=0, write_addr=0, data_out=0, busy=0, done=0, weights_valid=0.

## Timing
- Latency from beat accept to buffer write strobe: 1 cycle.
- Minimum load time, with s_valid held high: start at cycle 0 → LOAD at cycle 1.
  - Beats accepted at cycles 1..SIZE.
  - Writes at cycles 2..SIZE+1; DONE and done at cycle SIZE+1.
  - weights_valid=1 from cycle SIZE+2, when the buffer has captured the last word.
- Throughput: one weight per cycle.
- Back-to-back loads: start may be asserted in the first IDLE cycle after DONE. weights_valid then drops on that edge.
- abort and a valid beat in the same LOAD cycle: abort wins and the beat is not consumed.

## Test plan
- Reset values: hold rst_n=0, then release → all outputs 0, s_ready=0.
- Full load, SIZE=9, continuous stream 0x11..0x99 from start → writes at addr 0..8 with data 0x11..0x99 in order.
  - done at the cycle of the addr-8 write; weights_valid=1 one cycle later.
  - A downstream buffer model holds all nine words.
- Stalled stream: s_valid toggling 1,0,0,1,… → write_addr strictly sequential, no duplicate or skipped address, no write without an accepted beat.
  - done only after the 9th accept.
- Abort after 4 accepts, with s_valid=1 in the abort cycle → s_ready=0 that cycle, no 5th write, no done, weights_valid=0, IDLE next cycle.
  - A subsequent start loads all 9 words starting from addr 0.
- start pulses while busy → ignored; the load completes normally with exactly 9 writes.
  - start in the first IDLE cycle after DONE → weights_valid falls next cycle and a new load begins.
- Reset mid-load, asserting rst_n=0 after 5 accepts → all outputs 0 immediately (asynchronous).
  - After release: IDLE, weights_valid=0, and a new load writes from addr 0.
